// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and an AUX master.
// CPU has priority; AUX is force-granted after STARVE_LIMIT consecutive losses.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             aux_req,
  input  logic             aux_we,
  input  logic [31:0]      aux_addr,
  input  logic [31:0]      aux_wdata,
  output logic             aux_ack,
  output logic [31:0]      aux_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int unsigned WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic              aux_ack_q, aux_ack_d;
  logic [31:0]       aux_rdata_q, aux_rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;
  logic              cpu_act, aux_pend, grant_aux;

  always_comb begin
    cpu_act   = cpu_re | cpu_we;
    aux_pend  = aux_req & ~aux_ack_q;
    // Gating with reset keeps a request held during reset from being granted.
    grant_aux = reset & aux_pend & (~cpu_act | (wait_q == WAIT_MAX));

    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = cpu_re;
    mem_write = cpu_we;
    if (grant_aux) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_read  = ~aux_we;
      mem_write = aux_we;
    end

    cpu_stall = grant_aux & cpu_act;
    cpu_rdata = (~grant_aux & cpu_re) ? mem_rdata : 32'h0;

    aux_ack_d   = grant_aux;
    aux_rdata_d = (grant_aux & ~aux_we) ? mem_rdata : aux_rdata_q;

    wait_d = wait_q;
    if (grant_aux) begin
      wait_d = '0;
    end else if (aux_pend && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    conflict_d = conflict_q;
    if (cpu_stall && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_d = conflict_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= 32'h0;
      wait_q      <= '0;
      conflict_q  <= '0;
    end else begin
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
      wait_q      <= wait_d;
      conflict_q  <= conflict_d;
    end
  end

  assign aux_ack      = aux_ack_q;
  assign aux_rdata    = aux_rdata_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: main instance with a memory model, plus
// STARVE_LIMIT=0 and CNT_W=4 instances sharing the same stimulus.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_re, cpu_we, aux_req, aux_we;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [31:0] alt_rdata;

  logic [31:0] m_cpu_rdata, m_aux_rdata, m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic        m_cpu_stall, m_aux_ack, m_mem_read, m_mem_write;
  logic [15:0] m_cnt;

  logic [31:0] z_cpu_rdata, z_aux_rdata, z_mem_addr, z_mem_wdata;
  logic        z_cpu_stall, z_aux_ack, z_mem_read, z_mem_write;
  logic [15:0] z_cnt;

  logic [31:0] s_cpu_rdata, s_aux_rdata, s_mem_addr, s_mem_wdata;
  logic        s_cpu_stall, s_aux_ack, s_mem_read, s_mem_write;
  logic [3:0]  s_cnt;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) u_main (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(m_cpu_rdata), .cpu_stall(m_cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(m_aux_ack), .aux_rdata(m_aux_rdata),
    .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata), .mem_read(m_mem_read),
    .mem_write(m_mem_write), .mem_rdata(m_mem_rdata), .conflict_cnt(m_cnt)
  );

  dmem_arbiter #(.STARVE_LIMIT(0), .CNT_W(16)) u_s0 (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(z_aux_ack), .aux_rdata(z_aux_rdata),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_read(z_mem_read),
    .mem_write(z_mem_write), .mem_rdata(alt_rdata), .conflict_cnt(z_cnt)
  );

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(s_aux_ack), .aux_rdata(s_aux_rdata),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .mem_rdata(alt_rdata), .conflict_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_mem_rdata = mem[m_mem_addr[11:2]];
  always @(posedge clk) begin
    if (m_mem_write) mem[m_mem_addr[11:2]] <= m_mem_wdata;
  end

  typedef struct {
    logic        cre, cwe;
    logic [31:0] caddr, cwdata;
    logic        areq, awe;
    logic [31:0] aaddr, awdata;
    logic        e_stall, e_rd, e_wr;
    logic [31:0] e_maddr, e_mwdata, e_crdata;
    logic        e_ack;
    logic [31:0] e_ardata;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(
    logic cre, logic cwe, logic [31:0] caddr, logic [31:0] cwdata,
    logic areq, logic awe, logic [31:0] aaddr, logic [31:0] awdata,
    logic st, logic rd, logic wr, logic [31:0] ma, logic [31:0] mw,
    logic [31:0] crd, logic ack, logic [31:0] ard, logic [15:0] cnt);
    vec_t v;
    v.cre = cre; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.areq = areq; v.awe = awe; v.aaddr = aaddr; v.awdata = awdata;
    v.e_stall = st; v.e_rd = rd; v.e_wr = wr; v.e_maddr = ma; v.e_mwdata = mw;
    v.e_crdata = crd; v.e_ack = ack; v.e_ardata = ard; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_re = v.cre; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
    aux_req = v.areq; aux_we = v.awe; aux_addr = v.aaddr; aux_wdata = v.awdata;
  endtask

  initial begin
    int nst;
    logic exp_st;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h400 >> 2] = 32'h55;
    mem[32'h404 >> 2] = 32'h66;
    mem[32'h20 >> 2]  = 32'h1234;
    alt_rdata = 32'h77;

    // Reset with AUX requesting and CPU reading: CPU owns, nothing granted.
    reset = 1'b0;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400; cpu_wdata = 32'h0;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h20; aux_wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    #2;
    chk("rst_ack", 32'(m_aux_ack), 32'h0);
    chk("rst_cnt", 32'(m_cnt), 32'h0);
    chk("rst_mem_read", 32'(m_mem_read), 32'h1);
    chk("rst_mem_addr", m_mem_addr, 32'h400);
    chk("rst_stall", 32'(m_cpu_stall), 32'h0);
    chk("rst_s0_stall", 32'(z_cpu_stall), 32'h0);
    chk("rst_s0_mem_addr", z_mem_addr, 32'h400);
    chk("rst_ardata", m_aux_rdata, 32'h0);

    @(negedge clk);
    reset = 1'b1; cpu_re = 1'b0;
    #2;
    chk("rel_grant_addr", m_mem_addr, 32'h20);
    chk("rel_grant_read", 32'(m_mem_read), 32'h1);
    @(negedge clk);
    aux_req = 1'b0;
    #2;
    chk("rel_ack", 32'(m_aux_ack), 32'h1);
    chk("rel_ardata", m_aux_rdata, 32'h1234);

    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst2_ardata", m_aux_rdata, 32'h0);
    chk("rst2_ack", 32'(m_aux_ack), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // cre cwe caddr cwdata areq awe aaddr awdata | st rd wr maddr mwdata crdata ack ardata cnt
    vecs.push_back(mk(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,0,0,32'h0,0));
    vecs.push_back(mk(0,0,32'h0,32'h0, 1,0,32'h400,32'h0,  0,1,0,32'h400,32'h0,0,0,32'h0,0));
    vecs.push_back(mk(0,0,32'h0,32'h0, 0,0,32'h400,32'h0,  0,0,0,32'h0,32'h0,0,1,32'h55,0));
    vecs.push_back(mk(0,0,32'h0,32'h0, 0,0,32'h0,32'h0,    0,0,0,32'h0,32'h0,0,0,32'h55,0));
    vecs.push_back(mk(1,0,32'h20,32'h0, 0,0,32'h0,32'h0,   0,1,0,32'h20,32'h0,32'h1234,0,32'h55,0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,32'h20,32'h0, 1,0,32'h404,32'h0, 0,1,0,32'h20,32'h0,32'h1234,0,32'h55,0));
    vecs.push_back(mk(1,0,32'h20,32'h0, 1,0,32'h404,32'h0, 1,1,0,32'h404,32'h0,32'h0,0,32'h55,0));
    vecs.push_back(mk(1,0,32'h20,32'h0, 0,0,32'h404,32'h0, 0,1,0,32'h20,32'h0,32'h1234,1,32'h66,1));
    vecs.push_back(mk(1,0,32'h20,32'h0, 0,0,32'h0,32'h0,   0,1,0,32'h20,32'h0,32'h1234,0,32'h66,1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,32'h20,32'h0, 1,1,32'h10,32'hBB, 0,1,0,32'h20,32'h0,32'h1234,0,32'h66,1));
    vecs.push_back(mk(0,1,32'h10,32'hAA, 1,1,32'h10,32'hBB, 1,0,1,32'h10,32'hBB,32'h0,0,32'h66,1));
    vecs.push_back(mk(0,1,32'h10,32'hAA, 0,0,32'h0,32'h0,   0,0,1,32'h10,32'hAA,32'h0,1,32'h66,2));
    vecs.push_back(mk(1,0,32'h10,32'h0, 0,0,32'h0,32'h0,    0,1,0,32'h10,32'h0,32'hAA,0,32'h66,2));
    vecs.push_back(mk(0,0,32'h0,32'h0, 1,1,32'h10,32'hCC,   0,0,1,32'h10,32'hCC,32'h0,0,32'h66,2));
    vecs.push_back(mk(1,0,32'h10,32'h0, 0,0,32'h0,32'h0,    0,1,0,32'h10,32'h0,32'hCC,1,32'h66,2));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d_stall", i), 32'(m_cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_mem_read", i), 32'(m_mem_read), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_mem_write", i), 32'(m_mem_write), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_mem_addr", i), m_mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d_mem_wdata", i), m_mem_wdata, vecs[i].e_mwdata);
      chk($sformatf("v%0d_cpu_rdata", i), m_cpu_rdata, vecs[i].e_crdata);
      chk($sformatf("v%0d_aux_ack", i), 32'(m_aux_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_aux_rdata", i), m_aux_rdata, vecs[i].e_ardata);
      chk($sformatf("v%0d_cnt", i), 32'(m_cnt), 32'(vecs[i].e_cnt));
      @(negedge clk);
    end

    // STARVE_LIMIT=0: AUX wins immediately, never in its own ack cycle.
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h30;
    #2;
    chk("s0_a_stall", 32'(z_cpu_stall), 32'h1);
    chk("s0_a_mem_addr", z_mem_addr, 32'h30);
    chk("s0_a_cpu_rdata", z_cpu_rdata, 32'h0);
    @(negedge clk);
    #2;
    chk("s0_b_stall", 32'(z_cpu_stall), 32'h0);
    chk("s0_b_mem_addr", z_mem_addr, 32'h20);
    chk("s0_b_ack", 32'(z_aux_ack), 32'h1);
    chk("s0_b_ardata", z_aux_rdata, 32'h77);
    chk("s0_b_cpu_rdata", z_cpu_rdata, 32'h77);
    @(negedge clk);
    #2;
    chk("s0_c_stall", 32'(z_cpu_stall), 32'h1);
    @(negedge clk);
    aux_req = 1'b0;
    #2;
    chk("s0_d_stall", 32'(z_cpu_stall), 32'h0);
    chk("s0_d_ack", 32'(z_aux_ack), 32'h1);

    // Saturation on the 4-bit counter: held contention stalls every 6th cycle.
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("sat_rst_cnt", 32'(s_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cpu_re = 1'b1; aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h30;
    nst = 0;
    for (int i = 0; i < 126; i++) begin
      #2;
      exp_st = ((i % 6) == 4);
      chk($sformatf("sat_c%0d_stall", i), 32'(s_cpu_stall), 32'(exp_st));
      chk($sformatf("sat_c%0d_cnt", i), 32'(s_cnt), 32'((nst > 15) ? 15 : nst));
      if (exp_st) nst++;
      @(negedge clk);
    end
    aux_req = 1'b0; cpu_re = 1'b0;
    #2;
    chk("sat_final_cnt", 32'(s_cnt), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline's MEM stage (CPU port) and an auxiliary requester such as a loader, debug or DMA engine (AUX port). The CPU port has priority, and the AUX port gets a guaranteed slot after a bounded wait. The block sits between the MEM stage / AUX master and the data memory. It drives the memory's address, write-data, read and write strobes, and returns a stall to the pipeline whenever the CPU loses a cycle.

## Interface
- `STARVE_LIMIT`, default 4: maximum number of consecutive cycles a pending AUX request can lose to the CPU. A value of 0 means AUX always wins.
- `CNT_W`, default 16: width of the conflict counter.

- `clk` input 1: system clock. All registers update on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpu_re` input 1: CPU read request. Combinational and valid every cycle.
- `cpu_we` input 1: CPU write request.
- `cpu_addr` input 32: CPU byte address.
- `cpu_wdata` input 32: CPU write data.
- `cpu_rdata` output 32: CPU read data.
- `cpu_stall` output 1: CPU access not performed this cycle. The pipeline must hold its MEM stage.
- `aux_req` input 1: AUX request. Held high, with the fields below stable, until `aux_ack` is seen.
- `aux_we` input 1: AUX access type. 1 = write, 0 = read.
- `aux_addr` input 32: AUX byte address.
- `aux_wdata` input 32: AUX write data.
- `aux_ack` output 1: one-cycle completion pulse.
- `aux_rdata` output 32: registered AUX read data, valid while `aux_ack` = 1.
- `mem_addr` output 32: address to the data memory.
- `mem_wdata` output 32: write data to the data memory.
- `mem_read` output 1: read strobe to the data memory.
- `mem_write` output 1: write strobe to the data memory. The memory commits the write on the rising edge.
- `mem_rdata` input 32: combinational read data from the data memory.
- `conflict_cnt` output CNT_W: count of cycles in which the CPU was stalled. Saturates at all-ones.

## Operation
Definitions:
- `cpu_act = cpu_re | cpu_we`
- `aux_pend = aux_req & ~aux_ack`. A request is never re-granted during its own ack cycle.

Grant rule, evaluated combinationally each cycle:
- `grant_aux = aux_pend & (~cpu_act | (wait_cnt == STARVE_LIMIT))`.
- Otherwise the CPU owns the memory, even when `cpu_act` = 0.

Memory-side outputs:
- **CPU owns:**
  - `mem_addr`/`mem_wdata` = CPU fields.
  - `mem_read` = `cpu_re`.
  - `mem_write` = `cpu_we`.
- **AUX owns:**
  - `mem_addr`/`mem_wdata` = AUX fields.
  - `mem_read` = `~aux_we`.
  - `mem_write` = `aux_we`.
- If both `cpu_re` and `cpu_we` are high, both strobes pass through unchanged. The CPU never issues both.

CPU-side outputs:
- `cpu_stall = grant_aux & cpu_act`.
- `cpu_rdata = mem_rdata` when the CPU owns and `cpu_re` = 1, else 32'h0.

AUX completion, on the edge ending a `grant_aux` cycle:
- `aux_ack` <= 1.
- `aux_rdata` <= `mem_rdata` for reads. It holds its previous value for writes.
- `aux_ack` returns to 0 after exactly one cycle.

`wait_cnt` (internal, width = clog2(STARVE_LIMIT+1)):
- Cleared on `grant_aux`.
- Incremented when `aux_pend` & ~`grant_aux`, saturating at STARVE_LIMIT.
- Holds otherwise.

`conflict_cnt` increments on every cycle with `cpu_stall` = 1, saturating at all-ones.

Fairness:
- After a forced AUX grant, the following cycle is the ack cycle. Since `aux_pend` = 0 there, the CPU is never stalled two cycles in a row.
- AUX waits at most STARVE_LIMIT+1 cycles from `aux_req` rising to grant.

## Timing
- **Reset (`reset` = 0, asynchronous):**
  - `aux_ack` = 0, `aux_rdata` = 0, `wait_cnt` = 0, `conflict_cnt` = 0.
  - Combinational outputs follow the inputs with the CPU owning the memory. If `aux_req` = 1 during reset, it must not be granted until reset is released.
- **Reset mid-operation:**
  - A pending or just-granted AUX access loses its ack. A write may or may not have committed.
  - The AUX master re-issues the request. A request still held after reset is served normally.
- **Latency:**
  - CPU, uncontended: 0 cycles. Same-cycle read data, write committed at the edge.
  - AUX, uncontended: grant in the same cycle `aux_req` rises; `aux_ack` on the next cycle.
- **Back-to-back AUX:** the master may drop `aux_req` in the ack cycle, or keep it high with new fields. A held request is a new request, eligible from the cycle after ack.
- **Simultaneous CPU write and AUX write to the same address:** only the granted one reaches memory. The stalled CPU write retries on the next cycle and lands last.

## Test plan
1. **Reset:** hold `reset` = 0 with `aux_req` = 1 and `cpu_re` = 1 → `aux_ack` = 0, `conflict_cnt` = 0, `mem_read` = 1 with `mem_addr` = `cpu_addr`, `cpu_stall` = 0. After release with no CPU activity, AUX is granted in the first cycle.
2. **Uncontended AUX read:** `aux_req` = 1, `aux_we` = 0, `aux_addr` = 0x400, memory word = 0x55 → grant in cycle 0; in cycle 1, `aux_ack` = 1 and `aux_rdata` = 0x55; `aux_ack` = 0 in cycle 2.
3. **Starvation bound:** `cpu_re` = 1 every cycle with STARVE_LIMIT = 4 and `aux_req` raised at cycle 0 → CPU served in cycles 0–3; AUX granted in cycle 4 with `cpu_stall` = 1; `aux_ack` in cycle 5 with `cpu_stall` = 0; `conflict_cnt` = 1.
4. **Same-address write contention:** after `wait_cnt` reaches its limit, CPU writes 0xAA and AUX writes 0xBB to 0x10 in the same cycle → AUX written first, CPU stalled; next cycle the CPU write proceeds; final read of 0x10 = 0xAA.
5. **STARVE_LIMIT = 0:** CPU active and `aux_req` high → AUX granted immediately, CPU stalled one cycle, then CPU served in the ack cycle.
6. **Counter saturation with CNT_W = 4:** force 20 stall cycles → `conflict_cnt` stays at 0xF.
